// File: rtl/imem_fetch_arb_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch arbiter.
package imem_fetch_arb_pkg;
  localparam int IMEM_AW = 6;
  localparam int IMEM_DW = 32;
  localparam logic [IMEM_AW-1:0] RESET_PC = '0;
  localparam logic [IMEM_DW-1:0] NOP = 32'h00000000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ACK   = 1'b1
  } state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: redirect load has priority over sequential increment.
module fetch_pc_reg #(
  parameter int AW = imem_fetch_arb_pkg::IMEM_AW,
  parameter logic [AW-1:0] RESET_PC = imem_fetch_arb_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_pc,
  input  logic          inc,
  output logic [AW-1:0] pc
);
  import imem_fetch_arb_pkg::*;

  // Increment wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (load)
      pc <= load_pc;
    else if (inc)
      pc <= pc + AW'(1);
  end
endmodule

// File: rtl/imem_fetch_arb.sv
// Instruction fetch sequencer sharing one imem port with a debug reader;
// fetch has priority until a debug request has waited MAX_WAIT cycles.
module imem_fetch_arb #(
  parameter int AW = imem_fetch_arb_pkg::IMEM_AW,
  parameter int DW = imem_fetch_arb_pkg::IMEM_DW,
  parameter logic [AW-1:0] RESET_PC = imem_fetch_arb_pkg::RESET_PC,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_data,
  output logic [AW-1:0] pc
);
  import imem_fetch_arb_pkg::*;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_next;
  logic       fetch_want;
  logic       dbg_grant;
  logic       do_fetch;

  fetch_pc_reg #(
    .AW      (AW),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (redirect_valid),
    .load_pc(redirect_pc),
    .inc    (do_fetch),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_FETCH;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    dbg_grant  = 1'b0;
    wait_next  = wait_cnt;
    fetch_want = en && (!inst_valid || inst_ready) && !redirect_valid;
    case (state)
      ST_FETCH: begin
        dbg_grant = dbg_req && (!fetch_want || wait_cnt == MAX_WAIT_C);
        if (dbg_grant)
          state_next = ST_ACK;
      end
      // ACK blocks a second grant while the requester is still dropping dbg_req.
      ST_ACK:  state_next = ST_FETCH;
      default: state_next = ST_FETCH;
    endcase
    if (dbg_grant || !dbg_req)
      wait_next = '0;
    else if (state == ST_FETCH && wait_cnt != MAX_WAIT_C)
      wait_next = wait_cnt + 4'd1;
    do_fetch  = fetch_want && !dbg_grant;
    imem_addr = dbg_grant ? dbg_addr : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      inst       <= DW'(NOP);
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_data   <= '0;
    end else begin
      wait_cnt <= wait_next;
      dbg_ack  <= dbg_grant;
      if (dbg_grant)
        dbg_data <= imem_data;
      if (do_fetch) begin
        inst    <= imem_data;
        inst_pc <= pc;
      end
      // Redirect flushes even a stalled instruction.
      if (redirect_valid)
        inst_valid <= 1'b0;
      else if (do_fetch)
        inst_valid <= 1'b1;
      else if (inst_valid && inst_ready)
        inst_valid <= 1'b0;
    end
  end
endmodule

// File: doc/imem_fetch_arb.md
Name: imem_fetch_arb

Overview:
- Sequences the single-cycle core's 64-word instruction memory: owns the PC, drives the imem word address and registers the returned instruction toward decode with a valid/ready handshake.
- Shares that same imem port with a debug/monitor reader, using fetch-priority arbitration with a starvation bound.
- Sits between imem and the decode stage. The core supplies redirect requests for taken branches and jumps.

Parameters:
- AW, 6, imem word-address width (64 words)
- DW, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- MAX_WAIT, 4, number of consecutive ungranted debug-request cycles after which debug preempts fetch (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  fetch enable (core run)
- imem_addr  out  AW  word address to imem (combinational from grant mux)
- imem_data  in  DW  imem read data (combinational, same cycle)
- inst  out  DW  registered instruction to decode
- inst_pc  out  AW  PC of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts inst this cycle
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_pc  in  AW  new PC (absolute word address, already computed by the datapath)
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  AW  debug read address, stable while dbg_req=1
- dbg_ack  out  1  one-cycle pulse; dbg_data valid this cycle
- dbg_data  out  DW  registered debug read data
- pc  out  AW  current fetch PC (observability)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, dbg_ack=0, dbg_data=0, wait_cnt=0, state=FETCH. imem_addr follows pc.
- fetch_want = en && (!inst_valid || inst_ready) && !redirect_valid.
- dbg_grant (FETCH state only) = dbg_req && (!fetch_want || wait_cnt == MAX_WAIT).
- Priority each cycle, highest first:
  1. redirect_valid: pc<=redirect_pc; inst_valid<=0 (flush, even if decode is not ready); no fetch this cycle. dbg_grant is still evaluated.
  2. dbg_grant: imem_addr=dbg_addr; next edge dbg_data<=imem_data, dbg_ack<=1, state<=ACK, wait_cnt<=0.
  3. fetch_want: imem_addr=pc; next edge inst<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+1 (mod 2^AW, so 63 wraps to 0).
  4. Otherwise: hold. inst_valid<=0 only if inst_ready was 1 while inst_valid=1.
- Fetch-to-inst latency is 1 cycle. Sustained throughput is 1 instruction/cycle while inst_ready=1 and there is no debug grant.
- When debug takes a cycle that fetch wanted: pc is unchanged. inst_valid<=0 if the current inst was consumed that cycle, else inst is held.
- wait_cnt: increments (saturating at MAX_WAIT) each FETCH cycle with dbg_req=1 and no grant. Clears on grant or when dbg_req=0.
- State FSM:
  - FETCH -> ACK on dbg_grant.
  - ACK -> FETCH unconditionally after 1 cycle.
  - In ACK, dbg_grant is forced 0. This prevents a double grant while the requester drops dbg_req. Fetch proceeds normally in ACK.
- dbg_ack is high exactly one cycle per grant. dbg_data holds its value until the next grant.
- en=0: no fetch, pc frozen. A valid inst remains until consumed. Debug is granted immediately (next-cycle ack).
- redirect_valid with inst_valid=0: takes effect identically; the flush is a no-op.
- Reset mid-operation (mid-debug or mid-stall): all state is returned to reset values asynchronously. A pending debug request restarts arbitration after reset release.

Decomposition:
- Shared package holds:
  - IMEM_AW=6, IMEM_DW=32, RESET_PC
  - FSM state encoding (ST_FETCH=0, ST_ACK=1)
  - NOP=32'h00000000
- One natural sub-module, fetch_pc_reg: PC register with increment/wrap and redirect load.
- Arbiter, wait counter and output registers stay in imem_fetch_arb.

Test Plan:
- Reset, imem loaded with program (word0=32'h00001820, word1=32'h2001000A, word2=32'h00231820), en=1, inst_ready=1 -> inst_valid rises 1 cycle after reset release; inst/inst_pc = 00001820/0, 2001000A/1, 00231820/2 on consecutive cycles.
- Hold inst_ready=0 for 3 cycles at inst_pc=3 -> inst=32'hAC030001 and pc=4 held stable; on release, inst_pc=4 the next cycle.
- redirect_valid pulse with redirect_pc=0 while inst_pc=6 is valid and inst_ready=0 -> inst_valid=0 next cycle; inst_pc=0 (inst=00001820) the cycle after.
- en=0, dbg_req=1, dbg_addr=3 -> dbg_ack=1 next cycle with dbg_data=32'hAC030001; dbg_req held through the ACK cycle -> exactly one ack.
- en=1, inst_ready=1 continuous, dbg_req=1 at addr 6 -> grant after 4 waiting cycles; dbg_data=32'h1480FFF6; fetch skips exactly one cycle and pc sequence is unbroken.
- Run from redirect_pc=62 -> inst_pc 62, 63, 0, 1; also assert rst_n=0 during a debug ACK cycle -> dbg_ack=0, inst_valid=0, pc=0 immediately.
